// File: rtl/spi_txn_scheduler.sv
// spi_txn_scheduler: round-robin arbiter for single-byte SPI transactions that
// sequences an SPI controller through its APB register port.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req                 per-requester request, held until its done pulse
//   req_addr, req_data  per-requester SPI address/data byte, slice i = [i*WIDTH +: WIDTH]
//   done                one-cycle completion pulse to the granted requester
//   err                 valid with done; 1 = status poll timed out
//   rsp_data            data-slot readback, valid with done
//   busy                high from grant until the done cycle
//   paddr, pwrite,      APB master signals towards the SPI controller
//   pwdata, penable
//   pready, prdata      APB slave response
module spi_txn_scheduler #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned POLL_LIMIT = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       done,
  output logic                     err,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     busy,
  output logic [WIDTH-1:0]         paddr,
  output logic                     pwrite,
  output logic [WIDTH-1:0]         pwdata,
  output logic                     penable,
  input  logic                     pready,
  input  logic [WIDTH-1:0]         prdata
);

  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned POLL_W = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT) : 1;

  localparam logic [WIDTH-1:0]  ADDR_SLOT  = WIDTH'(8'h00);
  localparam logic [WIDTH-1:0]  DATA_SLOT  = WIDTH'(8'h10);
  localparam logic [WIDTH-1:0]  CTRL_REG   = WIDTH'(8'h20);
  localparam logic [WIDTH-1:0]  CTRL_START = WIDTH'(8'h01);
  localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_LIMIT - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_REQ - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_ADDR = 3'd1;
  localparam logic [2:0] WR_DATA = 3'd2;
  localparam logic [2:0] WR_CTRL = 3'd3;
  localparam logic [2:0] POLL    = 3'd4;
  localparam logic [2:0] CLR     = 3'd5;
  localparam logic [2:0] RD_DATA = 3'd6;
  localparam logic [2:0] DONE    = 3'd7;

  logic [2:0]         state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0]   cur_idx, cur_idx_nxt;
  logic [WIDTH-1:0]   cur_addr, cur_addr_nxt;
  logic [WIDTH-1:0]   cur_data, cur_data_nxt;
  logic [POLL_W-1:0]  poll_cnt, poll_cnt_nxt;
  logic               timeout, timeout_nxt;
  logic               stat_done, stat_done_nxt;
  logic               gap, gap_nxt;

  logic [NUM_REQ-1:0] done_nxt;
  logic               err_nxt;
  logic [WIDTH-1:0]   rsp_data_nxt;
  logic               busy_nxt;
  logic [WIDTH-1:0]   paddr_nxt;
  logic               pwrite_nxt;
  logic [WIDTH-1:0]   pwdata_nxt;
  logic               penable_nxt;

  logic               found;
  logic [IDX_W-1:0]   win;
  logic [WIDTH-1:0]   win_addr;
  logic [WIDTH-1:0]   win_data;
  int unsigned        pos;

  logic               launch;
  logic [2:0]         launch_st;

  // Round-robin pick: first set req bit at or after rr_ptr, plus its payload.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    win_addr = '0;
    win_data = '0;
    pos      = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = 32'(rr_ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (!found && req[IDX_W'(pos)]) begin
        found = 1'b1;
        win   = IDX_W'(pos);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == win) begin
        win_addr = req_addr[i*WIDTH +: WIDTH];
        win_data = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state and registered-output logic.
  // Every access state walks: launch (penable=1) -> wait pready -> one gap cycle.
  // The gap cycle decides the next state and launches its access directly.
  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    cur_idx_nxt   = cur_idx;
    cur_addr_nxt  = cur_addr;
    cur_data_nxt  = cur_data;
    poll_cnt_nxt  = poll_cnt;
    timeout_nxt   = timeout;
    stat_done_nxt = stat_done;
    gap_nxt       = gap;
    done_nxt      = '0;
    err_nxt       = 1'b0;
    rsp_data_nxt  = rsp_data;
    busy_nxt      = busy;
    paddr_nxt     = paddr;
    pwrite_nxt    = pwrite;
    pwdata_nxt    = pwdata;
    penable_nxt   = penable;
    launch        = 1'b0;
    launch_st     = state;

    case (state)
      IDLE: begin
        if (found) begin
          cur_idx_nxt  = win;
          cur_addr_nxt = win_addr;
          cur_data_nxt = win_data;
          rr_ptr_nxt   = (win == LAST_IDX) ? '0 : win + IDX_W'(1);
          timeout_nxt  = 1'b0;
          gap_nxt      = 1'b0;
          busy_nxt     = 1'b1;
          state_nxt    = WR_ADDR;
        end
      end
      DONE: begin
        timeout_nxt = 1'b0;
        state_nxt   = IDLE;
      end
      default: begin
        if (penable) begin
          if (pready) begin
            penable_nxt = 1'b0;
            gap_nxt     = 1'b1;
            if (state == POLL)    stat_done_nxt = prdata[7];
            if (state == RD_DATA) rsp_data_nxt  = prdata;
          end
        end else if (gap) begin
          gap_nxt = 1'b0;
          case (state)
            WR_ADDR: begin
              launch    = 1'b1;
              launch_st = WR_DATA;
            end
            WR_DATA: begin
              launch    = 1'b1;
              launch_st = WR_CTRL;
            end
            WR_CTRL: begin
              launch       = 1'b1;
              launch_st    = POLL;
              poll_cnt_nxt = '0;
            end
            POLL: begin
              launch = 1'b1;
              if (stat_done) begin
                launch_st = CLR;
              end else if (poll_cnt == POLL_LAST) begin
                timeout_nxt = 1'b1;
                launch_st   = CLR;
              end else begin
                poll_cnt_nxt = poll_cnt + POLL_W'(1);
                launch_st    = POLL;
              end
            end
            CLR: begin
              launch    = 1'b1;
              launch_st = RD_DATA;
            end
            default: begin
              state_nxt         = DONE;
              done_nxt[cur_idx] = 1'b1;
              err_nxt           = timeout;
              busy_nxt          = 1'b0;
            end
          endcase
        end else begin
          // First cycle after grant: nothing on the bus yet, start WR_ADDR.
          launch    = 1'b1;
          launch_st = state;
        end
      end
    endcase

    // Drive the APB access belonging to the state being entered.
    if (launch) begin
      state_nxt   = launch_st;
      penable_nxt = 1'b1;
      case (launch_st)
        WR_ADDR: begin
          paddr_nxt  = ADDR_SLOT;
          pwrite_nxt = 1'b1;
          pwdata_nxt = cur_addr;
        end
        WR_DATA: begin
          paddr_nxt  = DATA_SLOT;
          pwrite_nxt = 1'b1;
          pwdata_nxt = cur_data;
        end
        WR_CTRL: begin
          paddr_nxt  = CTRL_REG;
          pwrite_nxt = 1'b1;
          pwdata_nxt = CTRL_START;
        end
        CLR: begin
          paddr_nxt  = CTRL_REG;
          pwrite_nxt = 1'b1;
          pwdata_nxt = '0;
        end
        RD_DATA: begin
          paddr_nxt  = DATA_SLOT;
          pwrite_nxt = 1'b0;
          pwdata_nxt = '0;
        end
        default: begin
          paddr_nxt  = CTRL_REG;
          pwrite_nxt = 1'b0;
          pwdata_nxt = '0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cur_idx   <= '0;
      cur_addr  <= '0;
      cur_data  <= '0;
      poll_cnt  <= '0;
      timeout   <= 1'b0;
      stat_done <= 1'b0;
      gap       <= 1'b0;
      done      <= '0;
      err       <= 1'b0;
      rsp_data  <= '0;
      busy      <= 1'b0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      penable   <= 1'b0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      cur_idx   <= cur_idx_nxt;
      cur_addr  <= cur_addr_nxt;
      cur_data  <= cur_data_nxt;
      poll_cnt  <= poll_cnt_nxt;
      timeout   <= timeout_nxt;
      stat_done <= stat_done_nxt;
      gap       <= gap_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
      rsp_data  <= rsp_data_nxt;
      busy      <= busy_nxt;
      paddr     <= paddr_nxt;
      pwrite    <= pwrite_nxt;
      pwdata    <= pwdata_nxt;
      penable   <= penable_nxt;
    end
  end

endmodule
